// File: rtl/sprite_scheduler_pkg.sv
// rtl/sprite_scheduler_pkg.sv - shared types and default sizes for the sprite scheduler
package sprite_pkg;

    localparam int CORDW_DEFAULT      = 10;
    localparam int SPR_HEIGHT_DEFAULT = 8;

    // One sprite's position/enable register set; the same layout is used for
    // the software-written shadow copy and the frame-committed active copy.
    typedef struct packed {
        logic                     en;
        logic [CORDW_DEFAULT-1:0] x;
        logic [CORDW_DEFAULT-1:0] y;
    } spr_cfg_t;

endpackage

// File: rtl/sprite_scheduler_if.sv
// rtl/sprite_scheduler_if.sv - software-side shadow register write port
interface sprite_scheduler_if #(
    parameter int NSPR  = 4,
    parameter int CORDW = 10
);
    localparam int IW = $clog2(NSPR);

    logic             cfg_we;
    logic [IW-1:0]    cfg_idx;
    logic             cfg_en;
    logic [CORDW-1:0] cfg_x;
    logic [CORDW-1:0] cfg_y;

    modport master (output cfg_we, cfg_idx, cfg_en, cfg_x, cfg_y);
    modport slave  (input  cfg_we, cfg_idx, cfg_en, cfg_x, cfg_y);

endinterface

// File: rtl/sprite_line_fsm.sv
// rtl/sprite_line_fsm.sv - per-sprite line window tracker with start pulse and X latch
module sprite_line_fsm #(
    parameter int CORDW      = 10,
    parameter int SPR_HEIGHT = 8,
    parameter int V_RES      = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             line,
    input  logic [CORDW-1:0] sy,
    input  logic             en,
    input  logic [CORDW-1:0] x,
    input  logic [CORDW-1:0] y,
    output logic             start,
    output logic [CORDW-1:0] spr_x,
    output logic             drawing
);
    localparam int CW = $clog2(SPR_HEIGHT + 1);
    localparam logic [CORDW:0] VLIM = (CORDW+1)'(V_RES);

    typedef enum logic {IDLE, DRAW} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          hit;
    logic          last_line;

    // Lines at or beyond the active area never start, even though sy keeps
    // counting through vertical blanking.
    assign hit       = en && (sy == y) && ({1'b0, y} < VLIM);
    assign last_line = (state == DRAW) && (cnt == '0);
    // A line pulse that ends the window may immediately begin a new one.
    assign start     = line && hit && ((state == IDLE) || last_line);

    // Window state, remaining-line counter and draw X captured at start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            spr_x   <= '0;
            drawing <= 1'b0;
        end else if (start) begin
            state   <= DRAW;
            cnt     <= CW'(SPR_HEIGHT - 1);
            spr_x   <= x;
            drawing <= 1'b1;
        end else if (line && (state == DRAW)) begin
            if (cnt == '0) begin
                state   <= IDLE;
                drawing <= 1'b0;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_scheduler.sv
// rtl/sprite_scheduler.sv - double-buffered sprite registers, engine sequencing, merge and collisions
module sprite_scheduler
    import sprite_pkg::*;
#(
    parameter int NSPR       = 4,
    parameter int CORDW      = CORDW_DEFAULT,
    parameter int SPR_HEIGHT = SPR_HEIGHT_DEFAULT,
    parameter int V_RES      = 480
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CORDW-1:0]        sy,
    input  logic                    line,
    input  logic                    frame,
    sprite_scheduler_if.slave       cfg,
    input  logic [NSPR-1:0]         spr_pix,
    output logic [NSPR-1:0]         spr_start,
    output logic [NSPR*CORDW-1:0]   spr_x,
    output logic [NSPR-1:0]         drawing,
    output logic                    pix,
    output logic [$clog2(NSPR)-1:0] pix_id,
    output logic [NSPR-1:0]         collide
);
    localparam int IW = $clog2(NSPR);

    spr_cfg_t        shadow [NSPR];
    spr_cfg_t        active [NSPR];
    spr_cfg_t        wr_val;
    logic [NSPR-1:0] wr_hit;
    logic [IW-1:0]   win_id;
    logic            multi;
    logic [NSPR-1:0] acc;

    assign wr_val = {cfg.cfg_en, cfg.cfg_x, cfg.cfg_y};

    // Decode which sprite the write targets; indices past NSPR match nothing.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NSPR; i++) begin
            wr_hit[i] = cfg.cfg_we && (cfg.cfg_idx == IW'(i));
        end
    end

    // Shadow takes writes any time; active follows shadow only at frame, with
    // a same-cycle write forwarded so it lands in this frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSPR; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSPR; i++) begin
                if (wr_hit[i]) shadow[i] <= wr_val;
                if (frame)     active[i] <= wr_hit[i] ? wr_val : shadow[i];
            end
        end
    end

    for (genvar g = 0; g < NSPR; g++) begin : g_spr
        sprite_line_fsm #(
            .CORDW      (CORDW),
            .SPR_HEIGHT (SPR_HEIGHT),
            .V_RES      (V_RES)
        ) u_fsm (
            .clk     (clk),
            .rst_n   (rst_n),
            .line    (line),
            .sy      (sy),
            .en      (active[g].en),
            .x       (active[g].x),
            .y       (active[g].y),
            .start   (spr_start[g]),
            .spr_x   (spr_x[g*CORDW +: CORDW]),
            .drawing (drawing[g])
        );
    end

    // Fixed priority: scanning downward leaves the lowest set index.
    always_comb begin
        win_id = '0;
        for (int i = NSPR - 1; i >= 0; i--) begin
            if (spr_pix[i]) win_id = IW'(i);
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = (spr_pix & (spr_pix - NSPR'(1))) != '0;

    // Registered merge output and per-frame collision capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix     <= 1'b0;
            pix_id  <= '0;
            acc     <= '0;
            collide <= '0;
        end else begin
            pix    <= |spr_pix;
            pix_id <= win_id;
            if (frame) begin
                collide <= acc;
                acc     <= '0;
            end else if (multi) begin
                acc <= acc | spr_pix;
            end
        end
    end

endmodule

// File: tb/tb_sprite_scheduler.sv
// tb/tb_sprite_scheduler.sv - self-checking bench for sprite_scheduler
module tb_sprite_scheduler;
    localparam int NSPR = 4, CORDW = 10, SPR_HEIGHT = 8, V_RES = 480, LPC = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [CORDW-1:0]      sy;
    logic                  line, frame;
    logic [NSPR-1:0]       spr_pix;
    logic [NSPR-1:0]       spr_start, drawing, collide;
    logic [NSPR*CORDW-1:0] spr_x;
    logic                  pix;
    logic [1:0]            pix_id;

    sprite_scheduler_if #(.NSPR(NSPR), .CORDW(CORDW)) cfg_bus ();

    sprite_scheduler #(.NSPR(NSPR), .CORDW(CORDW), .SPR_HEIGHT(SPR_HEIGHT), .V_RES(V_RES)) dut (
        .clk(clk), .rst_n(rst_n), .sy(sy), .line(line), .frame(frame), .cfg(cfg_bus),
        .spr_pix(spr_pix), .spr_start(spr_start), .spr_x(spr_x), .drawing(drawing),
        .pix(pix), .pix_id(pix_id), .collide(collide)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: register copies plus, per sprite, whether a window is
    // open and how many line pulses have passed since it opened.
    bit              m_sh_en [NSPR];
    int              m_sh_x  [NSPR];
    int              m_sh_y  [NSPR];
    bit              m_ac_en [NSPR];
    int              m_ac_x  [NSPR];
    int              m_ac_y  [NSPR];
    bit              m_open  [NSPR];
    int              m_done  [NSPR];
    int              m_x     [NSPR];
    bit              m_pix;
    int              m_id;
    logic [NSPR-1:0] m_acc, m_col;
    logic [NSPR-1:0] exp_start_v, obs_start, line_start;

    task automatic model_reset();
        for (int i = 0; i < NSPR; i++) begin
            m_sh_en[i] = 0; m_sh_x[i] = 0; m_sh_y[i] = 0;
            m_ac_en[i] = 0; m_ac_x[i] = 0; m_ac_y[i] = 0;
            m_open[i] = 0; m_done[i] = 0; m_x[i] = 0;
        end
        m_pix = 0; m_id = 0; m_acc = '0; m_col = '0;
    endtask

    // A window spans SPR_HEIGHT line pulses; a sprite may start whenever the
    // current pulse leaves it with no window still open.
    function automatic bit model_start(int i);
        bit busy_after;
        busy_after = m_open[i] && (m_done[i] + 1 < SPR_HEIGHT);
        return line && m_ac_en[i] && (int'(sy) == m_ac_y[i]) && (m_ac_y[i] < V_RES) && !busy_after;
    endfunction

    task automatic model_step();
        logic [NSPR-1:0] st;
        int idx;
        for (int i = 0; i < NSPR; i++) st[i] = model_start(i);
        for (int i = 0; i < NSPR; i++) begin
            if (st[i]) begin
                m_open[i] = 1; m_done[i] = 0; m_x[i] = m_ac_x[i];
            end else if (line && m_open[i]) begin
                m_done[i]++;
                if (m_done[i] >= SPR_HEIGHT) m_open[i] = 0;
            end
        end
        m_pix = |spr_pix;
        m_id = 0;
        for (int i = NSPR - 1; i >= 0; i--) if (spr_pix[i]) m_id = i;
        if (frame) begin
            m_col = m_acc; m_acc = '0;
        end else if ($countones(spr_pix) > 1) begin
            m_acc = m_acc | spr_pix;
        end
        if (cfg_bus.cfg_we) begin
            idx = int'(cfg_bus.cfg_idx);
            m_sh_en[idx] = cfg_bus.cfg_en;
            m_sh_x[idx]  = int'(cfg_bus.cfg_x);
            m_sh_y[idx]  = int'(cfg_bus.cfg_y);
        end
        if (frame) begin
            for (int i = 0; i < NSPR; i++) begin
                m_ac_en[i] = m_sh_en[i]; m_ac_x[i] = m_sh_x[i]; m_ac_y[i] = m_sh_y[i];
            end
        end
    endtask

    // One clock: sample the combinational start mid-cycle, advance the model
    // with the edge, return at the following falling edge.
    task automatic cyc();
        #1;
        obs_start = spr_start;
        for (int i = 0; i < NSPR; i++) exp_start_v[i] = model_start(i);
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        @(negedge clk);
    endtask

    task automatic set_cfg(input bit we, input int idx, input bit en, input int x, input int y);
        cfg_bus.cfg_we  = we;
        cfg_bus.cfg_idx = 2'(idx);
        cfg_bus.cfg_en  = en;
        cfg_bus.cfg_x   = CORDW'(x);
        cfg_bus.cfg_y   = CORDW'(y);
    endtask

    task automatic line_cycle(input int s, input bit frm);
        sy = CORDW'(s); line = 1'b1; frame = frm;
        cyc();
        line_start = obs_start;
        line = 1'b0; frame = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        repeat (LPC - 1) cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; sy = '0; line = 1'b0; frame = 1'b0; spr_pix = '0;
        set_cfg(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (spr_start !== 4'b0) begin bad++; $display("FAIL reset_start got=%b want=0", spr_start); end
        total++; if (spr_x !== '0) begin bad++; $display("FAIL reset_spr_x got=%h want=0", spr_x); end
        total++; if (drawing !== 4'b0) begin bad++; $display("FAIL reset_drawing got=%b want=0", drawing); end
        total++; if ({pix, pix_id} !== 3'b0) begin bad++; $display("FAIL reset_pix got=%b/%0d want=0/0", pix, pix_id); end
        total++; if (collide !== 4'b0) begin bad++; $display("FAIL reset_collide got=%b want=0", collide); end
    endtask

    task automatic test_commit_and_move();
        bit early;
        do_reset();
        for (int s = 0; s < 10; s++) line_cycle(s, 0);
        set_cfg(1, 1, 1, 100, 50);
        early = 0;
        for (int s = 10; s <= 60; s++) begin
            line_cycle(s, 0);
            if (line_start[1] || drawing[1]) early = 1;
        end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL commit_before_frame got=%b want=0", early); end
        line_cycle(V_RES, 1);
        for (int s = 0; s <= 60; s++) begin
            line_cycle(s, 0);
            total++; if (line_start[1] !== (s == 50)) begin bad++; $display("FAIL commit_start sy=%0d got=%b want=%b", s, line_start[1], s == 50); end
            total++; if (drawing[1] !== (s >= 50 && s <= 57)) begin bad++; $display("FAIL commit_drawing sy=%0d got=%b want=%b", s, drawing[1], s >= 50 && s <= 57); end
            if (s >= 50) begin
                total++; if (spr_x[CORDW +: CORDW] !== 10'd100) begin bad++; $display("FAIL move_hold sy=%0d got=%0d want=100", s, spr_x[CORDW +: CORDW]); end
            end
            if (s == 53) begin
                set_cfg(1, 1, 1, 200, 50); frame = 1'b1;
                cyc();
                set_cfg(0, 0, 0, 0, 0); frame = 1'b0;
            end
        end
        line_cycle(V_RES, 1);
        for (int s = 0; s <= 50; s++) line_cycle(s, 0);
        total++; if (line_start[1] !== 1'b1) begin bad++; $display("FAIL move_restart got=%b want=1", line_start[1]); end
        total++; if (spr_x[CORDW +: CORDW] !== 10'd200) begin bad++; $display("FAIL move_new_x got=%0d want=200", spr_x[CORDW +: CORDW]); end
    endtask

    task automatic test_same_cycle_commit();
        do_reset();
        set_cfg(1, 0, 1, 5, 20);
        line_cycle(V_RES, 1);
        for (int s = 0; s <= 30; s++) begin
            line_cycle(s, 0);
            total++; if (line_start[0] !== (s == 20)) begin bad++; $display("FAIL same_cycle_start sy=%0d got=%b want=%b", s, line_start[0], s == 20); end
        end
        total++; if (spr_x[CORDW-1:0] !== 10'd5) begin bad++; $display("FAIL same_cycle_x got=%0d want=5", spr_x[CORDW-1:0]); end
    endtask

    task automatic test_merge_collide();
        do_reset();
        spr_pix = 4'b0110; cyc();
        total++; if ({pix, pix_id} !== {1'b1, 2'd1}) begin bad++; $display("FAIL merge_0110 got=%b/%0d want=1/1", pix, pix_id); end
        spr_pix = 4'b1000; cyc();
        total++; if ({pix, pix_id} !== {1'b1, 2'd3}) begin bad++; $display("FAIL merge_1000 got=%b/%0d want=1/3", pix, pix_id); end
        spr_pix = 4'b0000; cyc();
        total++; if ({pix, pix_id} !== 3'b0) begin bad++; $display("FAIL merge_none got=%b/%0d want=0/0", pix, pix_id); end
        total++; if (collide !== 4'b0) begin bad++; $display("FAIL collide_early got=%b want=0", collide); end
        frame = 1'b1; cyc(); frame = 1'b0;
        total++; if (collide !== 4'b0110) begin bad++; $display("FAIL collide_frame got=%b want=0110", collide); end
        repeat (3) cyc();
        total++; if (collide !== 4'b0110) begin bad++; $display("FAIL collide_hold got=%b want=0110", collide); end
        frame = 1'b1; cyc(); frame = 1'b0;
        total++; if (collide !== 4'b0) begin bad++; $display("FAIL collide_clear got=%b want=0", collide); end
    endtask

    task automatic test_vres();
        bit seen;
        do_reset();
        set_cfg(1, 2, 1, 7, V_RES);
        line_cycle(V_RES, 1);
        seen = 0;
        for (int s = V_RES - 10; s < V_RES + 10; s++) begin
            line_cycle(s, s == V_RES);
            if (line_start[2] || drawing[2]) seen = 1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL vres_start got=%b want=0", seen); end
    endtask

    task automatic test_async_reset();
        bit seen;
        do_reset();
        set_cfg(1, 3, 1, 33, 5); frame = 1'b1; cyc(); frame = 1'b0; set_cfg(0, 0, 0, 0, 0);
        spr_pix = 4'b1100; cyc(); spr_pix = 4'b0;
        frame = 1'b1; cyc(); frame = 1'b0;
        for (int s = 0; s <= 7; s++) line_cycle(s, 0);
        total++; if ({drawing[3], spr_x[3*CORDW +: CORDW], collide} !== {1'b1, 10'd33, 4'b1100}) begin
            bad++; $display("FAIL areset_pre got=%b/%0d/%b want=1/33/1100", drawing[3], spr_x[3*CORDW +: CORDW], collide);
        end
        spr_pix = 4'b0001; cyc(); spr_pix = 4'b0;
        sy = CORDW'(8); line = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({spr_start, drawing, collide, pix, pix_id} !== 15'b0) begin
            bad++; $display("FAIL areset_now start=%b draw=%b col=%b pix=%b id=%0d want all 0", spr_start, drawing, collide, pix, pix_id);
        end
        total++; if (spr_x !== '0) begin bad++; $display("FAIL areset_x got=%h want=0", spr_x); end
        line = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        seen = 0;
        for (int s = 0; s <= 10; s++) begin line_cycle(s, 0); if (line_start != 0 || drawing != 0) seen = 1; end
        line_cycle(V_RES, 1);
        for (int s = 0; s <= 10; s++) begin line_cycle(s, 0); if (line_start != 0 || drawing != 0) seen = 1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL areset_after got=%b want=0", seen); end
    endtask

    task automatic test_random();
        logic [NSPR*CORDW-1:0] exp_x;
        logic [NSPR-1:0]       exp_draw;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < V_RES + 10; s++) begin
                for (int c = 0; c < LPC; c++) begin
                    sy = CORDW'(s);
                    line = (c == 0);
                    frame = (c == 0) && (s == V_RES);
                    spr_pix = (!frame && $urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
                    if ($urandom_range(0, 39) == 0)
                        set_cfg(1, $urandom_range(0, NSPR - 1), ($urandom_range(0, 3) != 0),
                                $urandom_range(0, 1023),
                                ($urandom_range(0, 3) == 0) ? $urandom_range(V_RES - 10, V_RES + 9) : $urandom_range(0, V_RES - 1));
                    else
                        set_cfg(0, 0, 0, 0, 0);
                    cyc();
                    for (int i = 0; i < NSPR; i++) begin
                        exp_x[i*CORDW +: CORDW] = CORDW'(m_x[i]);
                        exp_draw[i] = m_open[i];
                    end
                    total++; if (obs_start !== exp_start_v) begin bad++; $display("FAIL rnd_start f=%0d sy=%0d got=%b want=%b", f, s, obs_start, exp_start_v); end
                    total++; if (drawing !== exp_draw) begin bad++; $display("FAIL rnd_drawing f=%0d sy=%0d got=%b want=%b", f, s, drawing, exp_draw); end
                    total++; if (spr_x !== exp_x) begin bad++; $display("FAIL rnd_spr_x f=%0d sy=%0d got=%h want=%h", f, s, spr_x, exp_x); end
                    total++; if ({pix, pix_id} !== {m_pix, 2'(m_id)}) begin bad++; $display("FAIL rnd_pix f=%0d sy=%0d got=%b/%0d want=%b/%0d", f, s, pix, pix_id, m_pix, m_id); end
                    total++; if (collide !== m_col) begin bad++; $display("FAIL rnd_collide f=%0d sy=%0d got=%b want=%b", f, s, collide, m_col); end
                end
            end
        end
        line = 1'b0; frame = 1'b0; spr_pix = '0; set_cfg(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; sy = '0; line = 1'b0; frame = 1'b0; spr_pix = '0;
        set_cfg(0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        test_reset();
        test_commit_and_move();
        test_same_cycle_commit();
        test_merge_collide();
        test_vres();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
